// File: rtl/alu32_scheduler_pkg.sv
// alu32_scheduler shared types and constants.
// Op codes, FSM encodings and flag bit positions.
package alu32_scheduler_pkg;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  localparam int FLG_C = 3;
  localparam int FLG_N = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    OP_NOTA = 3'b000,
    OP_NOTB = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ADD  = 3'b110,
    OP_SUB  = 3'b111
  } op_e;

  function automatic logic [N_REQ-1:0] onehot4(
    input logic [IDW-1:0] idx
  );
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/alu32_scheduler_if.sv
// Requester, ALU and response signals of the scheduler.
// slave = scheduler side, master = environment side.
interface alu32_scheduler_if;
  import alu32_scheduler_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [3*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_a;
  logic [WIDTH*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]       gnt;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  logic [3:0]       alu_flags;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [WIDTH-1:0] rsp_y;
  logic [3:0]       rsp_flags;
  logic             busy;

  modport slave (
    input  req, req_op, req_a, req_b,
    input  alu_y, alu_flags, rsp_ready,
    output gnt, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_y,
    output rsp_flags, busy
  );

  modport master (
    output req, req_op, req_a, req_b,
    output alu_y, alu_flags, rsp_ready,
    input  gnt, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_y,
    input  rsp_flags, busy
  );

endinterface

// File: rtl/alu32_scheduler_arb.sv
// Four-way round-robin arbiter, purely combinational.
// Rotate by pointer, pick lowest, rotate back.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] win_o,
  output logic       valid_o
);

  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] pick;

  // Search upward from ptr_i with wrap-around
  always_comb begin
    dbl  = {req_i, req_i};
    rot  = dbl[ptr_i +: 4];
    pick = 2'd0;
    priority case (1'b1)
      rot[0]:  pick = 2'd0;
      rot[1]:  pick = 2'd1;
      rot[2]:  pick = 2'd2;
      rot[3]:  pick = 2'd3;
      default: pick = 2'd0;
    endcase
    win_o   = pick + ptr_i;
    valid_o = |req_i;
  end

endmodule

// File: rtl/alu32_scheduler.sv
// Shares one external combinational ALU among four requesters.
// IDLE grants, EXEC captures the result, RESP holds it until taken.
module alu32_scheduler
  import alu32_scheduler_pkg::*;
(
  input logic              clk,
  input logic              reset,
  alu32_scheduler_if.slave bus
);

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   id_q;
  logic [N_REQ-1:0] gnt_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_op_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_y_q;
  logic [3:0]       rsp_flags_q;

  logic [IDW-1:0]   win;
  logic             win_vld;
  logic [WIDTH-1:0] win_a_d;
  logic [WIDTH-1:0] win_b_d;
  logic [2:0]       win_op_d;

  rr_arbiter4 u_arb (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .win_o   (win),
    .valid_o (win_vld)
  );

  // Slice out the winning requester's operands
  always_comb begin
    win_a_d  = bus.req_a[int'(win)*WIDTH +: WIDTH];
    win_b_d  = bus.req_b[int'(win)*WIDTH +: WIDTH];
    win_op_d = bus.req_op[int'(win)*3 +: 3];
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            alu_a_q  <= win_a_d;
            alu_b_q  <= win_b_d;
            alu_op_q <= win_op_d;
            gnt_q    <= onehot4(win);
            id_q     <= win;
            rr_ptr_q <= win + 2'd1;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          gnt_q       <= '0;
          rsp_y_q     <= bus.alu_y;
          rsp_flags_q <= bus.alu_flags;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_flags = rsp_flags_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
